// File: rtl/rns_fwd_converter.sv
// Iterative signed binary -> RNS forward converter for moduli {2^N-1, 2^N, 2^N+1}.
// Optional range check enabled by defining RNS_FWD_RANGE_CHK_EN (adds out_ovf).
module rns_fwd_converter #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3*N-1:0] in_x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_r1,
  output logic [N-1:0]   out_r2,
  output logic [N:0]     out_r3
`ifdef RNS_FWD_RANGE_CHK_EN
  ,
  output logic           out_ovf
`endif
);

  localparam logic [N-1:0] M1   = '1;
  localparam logic [N:0]   M3HI = (N+1)'(1 << N);
  localparam logic [N+1:0] MP1  = (N+2)'((1 << N) + 1);

  typedef enum logic [1:0] {IDLE, ACC, CORR, DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [3*N-1:0] x_q, x_d;
  logic [N-1:0]   acc1_q, acc1_d;
  logic [N:0]     acc3_q, acc3_d;
  logic [N-1:0]   r2_q, r2_d;
  logic [N-1:0]   out_r1_q, out_r1_d;
  logic [N-1:0]   out_r2_q, out_r2_d;
  logic [N:0]     out_r3_q, out_r3_d;
  logic           out_valid_q, out_valid_d;
  logic           ovf_q, ovf_d;
  logic [N-1:0]   chunk;
  logic [N-1:0]   fin1;

  // End-around carry add; result may be 2^N-1, which aliases 0 until normalised.
  function automatic logic [N-1:0] add_m1(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[N-1:0] + {{(N-1){1'b0}}, s[N]};
  endfunction

  function automatic logic [N:0] add_p1(input logic [N:0] a, input logic [N-1:0] c);
    logic [N+1:0] s;
    s = {1'b0, a} + {2'b00, c};
    if (s >= MP1) s = s - MP1;
    return s[N:0];
  endfunction

  function automatic logic [N:0] sub_p1(input logic [N:0] a, input logic [N-1:0] c);
    logic [N+1:0] s;
    if ({1'b0, a} >= {2'b00, c}) s = {1'b0, a} - {2'b00, c};
    else                         s = {1'b0, a} + MP1 - {2'b00, c};
    return s[N:0];
  endfunction

`ifdef RNS_FWD_RANGE_CHK_EN
  localparam logic signed [3*N:0] HALF_M = (3*N+1)'((2**(N-1)) * (2**(2*N) - 1));
  logic signed [3*N:0] xs;
  assign xs = {x_q[3*N-1], x_q};
`endif

  always_comb begin
    chunk = x_q[N-1:0];
    case (cnt_q)
      2'd1:    chunk = x_q[2*N-1:N];
      2'd2:    chunk = x_q[3*N-1:2*N];
      default: chunk = x_q[N-1:0];
    endcase
  end

  // Normalise the 2^N-1 alias first, then apply the -1 sign correction.
  always_comb begin
    fin1 = (acc1_q == M1) ? '0 : acc1_q;
    if (x_q[3*N-1]) fin1 = (fin1 == '0) ? M1 - 1'b1 : fin1 - 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    acc1_d      = acc1_q;
    acc3_d      = acc3_q;
    r2_d        = r2_q;
    out_r1_d    = out_r1_q;
    out_r2_d    = out_r2_q;
    out_r3_d    = out_r3_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          acc1_d  = '0;
          acc3_d  = '0;
          cnt_d   = 2'd0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc1_d = add_m1(acc1_q, chunk);
        acc3_d = (cnt_q == 2'd1) ? sub_p1(acc3_q, chunk) : add_p1(acc3_q, chunk);
        if (cnt_q == 2'd0) r2_d = chunk;
        if (cnt_q == 2'd2) state_d = CORR;
        else               cnt_d   = cnt_q + 2'd1;
      end
      CORR: begin
        out_r1_d    = fin1;
        out_r2_d    = r2_q;
        out_r3_d    = x_q[3*N-1] ? ((acc3_q == M3HI) ? '0 : acc3_q + 1'b1) : acc3_q;
        out_valid_d = 1'b1;
`ifdef RNS_FWD_RANGE_CHK_EN
        ovf_d       = (xs >= HALF_M) || (xs < -HALF_M);
`endif
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ovf_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      acc1_q      <= '0;
      acc3_q      <= '0;
      r2_q        <= '0;
      out_r1_q    <= '0;
      out_r2_q    <= '0;
      out_r3_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      acc1_q      <= acc1_d;
      acc3_q      <= acc3_d;
      r2_q        <= r2_d;
      out_r1_q    <= out_r1_d;
      out_r2_q    <= out_r2_d;
      out_r3_q    <= out_r3_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_r1    = out_r1_q;
  assign out_r2    = out_r2_q;
  assign out_r3    = out_r3_q;
`ifdef RNS_FWD_RANGE_CHK_EN
  assign out_ovf   = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rns_fwd_converter.sv
// Directed bench for rns_fwd_converter (N=3: moduli 7, 8, 9) with hand-computed residues.
module tb_rns_fwd_converter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_x;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_r1;
  logic [2:0] out_r2;
  logic [3:0] out_r3;
`ifdef RNS_FWD_RANGE_CHK_EN
  logic       out_ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rns_fwd_converter #(.N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r1    (out_r1),
    .out_r2    (out_r2),
    .out_r3    (out_r3)
`ifdef RNS_FWD_RANGE_CHK_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept x, walk the fixed 4-cycle latency, check residues; exit DONE when out_ready is high.
  task automatic conv(input string tag, input logic [8:0] x, input int e1, input int e2,
                      input int e3, input logic eovf);
    in_x     = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_x     = ~x;
    check({tag, " in_ready_acc"}, 32'(in_ready), 0);
    tick();
    tick();
    tick();
    check({tag, " valid_corr"}, 32'(out_valid), 0);
    check({tag, " in_ready_corr"}, 32'(in_ready), 0);
    tick();
    check({tag, " valid_done"}, 32'(out_valid), 1);
    check({tag, " in_ready_done"}, 32'(in_ready), 0);
    check({tag, " r1"}, 32'(out_r1), 32'(e1));
    check({tag, " r2"}, 32'(out_r2), 32'(e2));
    check({tag, " r3"}, 32'(out_r3), 32'(e3));
`ifdef RNS_FWD_RANGE_CHK_EN
    check({tag, " ovf"}, 32'(out_ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("[TB] unexpected x flag");
`endif
    if (out_ready) begin
      tick();
      check({tag, " valid_exit"}, 32'(out_valid), 0);
      check({tag, " in_ready_exit"}, 32'(in_ready), 1);
`ifdef RNS_FWD_RANGE_CHK_EN
      check({tag, " ovf_exit"}, 32'(out_ovf), 0);
`endif
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset r1", 32'(out_r1), 0);
    check("reset r2", 32'(out_r2), 0);
    check("reset r3", 32'(out_r3), 0);
`ifdef RNS_FWD_RANGE_CHK_EN
    check("reset ovf", 32'(out_ovf), 0);
`endif

    conv("x100",  9'd100,  2, 4, 1, 1'b0);
    conv("xm1",   9'h1FF,  6, 7, 8, 1'b0);
    conv("x0",    9'd0,    0, 0, 0, 1'b0);
    conv("x251",  9'd251,  6, 3, 8, 1'b0);
    conv("xm252", 9'd260,  0, 4, 0, 1'b0);
    conv("xm256", 9'd256,  3, 0, 5, 1'b1);
    conv("x255",  9'd255,  3, 7, 3, 1'b1);

    // Back-pressure: DONE holds for 10 cycles; in_valid there must be ignored.
    out_ready = 1'b0;
    conv("stall", 9'd100, 2, 4, 1, 1'b0);
    in_valid = 1'b1;
    in_x     = 9'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall valid", 32'(out_valid), 1);
      check("stall in_ready", 32'(in_ready), 0);
      check("stall r1", 32'(out_r1), 2);
      check("stall r2", 32'(out_r2), 4);
      check("stall r3", 32'(out_r3), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release valid", 32'(out_valid), 0);
    check("release in_ready", 32'(in_ready), 1);

    // Reset during ACC cnt=1.
    in_x     = 9'h1FF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_acc in_ready", 32'(in_ready), 1);
    check("rst_acc valid", 32'(out_valid), 0);
    check("rst_acc r1", 32'(out_r1), 0);
    check("rst_acc r3", 32'(out_r3), 0);
    conv("after_rst x100", 9'd100, 2, 4, 1, 1'b0);

    // Reset while a result is pending drops it.
    out_ready = 1'b0;
    conv("pend", 9'd251, 6, 3, 8, 1'b0);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    check("rst_done valid", 32'(out_valid), 0);
    check("rst_done in_ready", 32'(in_ready), 1);
    check("rst_done r1", 32'(out_r1), 0);
    check("rst_done r2", 32'(out_r2), 0);
    check("rst_done r3", 32'(out_r3), 0);
    conv("after_rst xm1", 9'h1FF, 6, 7, 8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
